servant_spi_bus_arbiter: RTL and testbench

Shares the single Wishbone SPI RAM master interface between the SERV instruction bus (read-only) and data bus (read/write). After reset, it issues one configuration transaction (write, all byte-selects zero) to the SPI RAM bridge before granting any requester. Arbitration is round-robin, and each grant is held until the transfer completes. A per-transfer watchdog aborts a transfer that never completes, so a stalled SPI device cannot hang the CPU.

---
 rtl/servant_spi_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_servant_spi_bus_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_spi_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone SPI RAM port between the SERV instruction
// and data buses, with a post-reset configuration write and a per-transfer watchdog.
module servant_spi_bus_arbiter #(
    parameter int ADDRESS_WIDTH  = 24,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 1,
    parameter bit INIT_ENABLE    = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-3:0] i_adr,
    input  logic                     i_cyc,
    output logic [31:0]              i_rdt,
    output logic                     i_ack,
    input  logic [ADDRESS_WIDTH-3:0] d_adr,
    input  logic [31:0]              d_dat,
    input  logic [3:0]               d_sel,
    input  logic                     d_we,
    input  logic                     d_cyc,
    output logic [31:0]              d_rdt,
    output logic                     d_ack,
    output logic [ADDRESS_WIDTH-3:0] m_adr,
    output logic [31:0]              m_dat,
    output logic [3:0]               m_sel,
    output logic                     m_we,
    output logic                     m_cyc,
    input  logic [31:0]              m_rdt,
    input  logic                     m_ack,
    output logic                     init_done,
    output logic                     timeout_err
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_GRANT_I,
        S_GRANT_D,
        S_ABORT,
        S_GAP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            r_last_d;
    logic            r_init_done;
    logic            r_timeout_err;
    logic            r_rst_hold;
    logic [31:0]     r_i_rdt;
    logic [31:0]     r_d_rdt;

    logic            w_timeout;
    logic            w_gap_done;
    logic            w_m_cyc;
    logic            w_i_ack;
    logic            w_d_ack;
    logic [31:0]     w_i_rdt;
    logic [31:0]     w_d_rdt;

    // r_rst_hold keeps the bus quiet for the first cycle after reset so the SPI bridge
    // sees m_cyc low before the configuration write starts.
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && !r_rst_hold && (r_cnt == TO_LAST) && !m_ack;
    assign w_gap_done = (r_cnt == GAP_LAST);

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (!reset) begin
            r_state <= INIT_ENABLE ? S_INIT : S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        w_next  = r_state;
        m_adr   = '0;
        m_dat   = '0;
        m_sel   = '0;
        m_we    = 1'b0;
        w_m_cyc = 1'b0;
        w_i_ack = 1'b0;
        w_d_ack = 1'b0;
        w_i_rdt = r_i_rdt;
        w_d_rdt = r_d_rdt;
        unique case (r_state)
            S_INIT: begin
                m_we    = 1'b1;
                w_m_cyc = !r_rst_hold;
                if (!r_rst_hold && (m_ack || w_timeout)) w_next = S_GAP;
            end
            S_IDLE: begin
                if (i_cyc && (!d_cyc || r_last_d)) w_next = S_GRANT_I;
                else if (d_cyc)                    w_next = S_GRANT_D;
            end
            S_GRANT_I: begin
                m_adr   = i_adr;
                m_sel   = 4'hF;
                w_m_cyc = 1'b1;
                w_i_rdt = m_rdt;
                w_i_ack = m_ack && i_cyc;
                if (m_ack)          w_next = S_GAP;
                else if (w_timeout) w_next = S_ABORT;
            end
            S_GRANT_D: begin
                m_adr   = d_adr;
                m_dat   = d_dat;
                m_sel   = d_sel;
                m_we    = d_we;
                w_m_cyc = 1'b1;
                w_d_rdt = m_rdt;
                w_d_ack = m_ack && d_cyc;
                if (m_ack)          w_next = S_GAP;
                else if (w_timeout) w_next = S_ABORT;
            end
            S_ABORT: begin
                // Bus already released; the stalled requester gets an all-ones error word.
                if (r_last_d) begin
                    w_d_ack = d_cyc;
                    w_d_rdt = 32'hFFFF_FFFF;
                end else begin
                    w_i_ack = i_cyc;
                    w_i_rdt = 32'hFFFF_FFFF;
                end
                w_next = S_GAP;
            end
            S_GAP: begin
                if (w_gap_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_last_d      <= 1'b0;
            r_init_done   <= !INIT_ENABLE;
            r_timeout_err <= 1'b0;
            r_rst_hold    <= 1'b1;
            r_i_rdt       <= '0;
            r_d_rdt       <= '0;
        end else begin
            r_rst_hold <= 1'b0;
            if (r_rst_hold || (w_next != r_state)) r_cnt <= '0;
            else                                   r_cnt <= r_cnt + CW'(1);
            if (r_state == S_IDLE && w_next == S_GRANT_I) r_last_d <= 1'b0;
            if (r_state == S_IDLE && w_next == S_GRANT_D) r_last_d <= 1'b1;
            if (r_state == S_INIT && w_next == S_GAP)     r_init_done <= 1'b1;
            if ((r_state == S_INIT && w_timeout) || r_state == S_ABORT) r_timeout_err <= 1'b1;
            if (w_i_ack) r_i_rdt <= w_i_rdt;
            if (w_d_ack) r_d_rdt <= w_d_rdt;
        end
    end

    // Reset gates the handshake outputs combinationally so an in-flight transfer is
    // dropped in the very cycle reset is asserted.
    assign m_cyc       = w_m_cyc & reset;
    assign i_ack       = w_i_ack & reset;
    assign d_ack       = w_d_ack & reset;
    assign i_rdt       = w_i_rdt;
    assign d_rdt       = w_d_rdt;
    assign init_done   = r_init_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_servant_spi_bus_arbiter.sv
// Transaction-level randomized bench: predicts grant order, bus fields, burst length,
// idle gaps, acks and sticky flags from the arbitration rules, with an SPI slave model.
module tb_servant_spi_bus_arbiter;

    localparam int AW  = 24;
    localparam int TO  = 16;
    localparam int GAP = 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-3:0] i_adr = '0;
    logic          i_cyc = 1'b0;
    logic [31:0]   i_rdt;
    logic          i_ack;
    logic [AW-3:0] d_adr = '0;
    logic [31:0]   d_dat = '0;
    logic [3:0]    d_sel = '0;
    logic          d_we  = 1'b0;
    logic          d_cyc = 1'b0;
    logic [31:0]   d_rdt;
    logic          d_ack;
    logic [AW-3:0] m_adr;
    logic [31:0]   m_dat;
    logic [3:0]    m_sel;
    logic          m_we;
    logic          m_cyc;
    logic [31:0]   m_rdt = '0;
    logic          m_ack = 1'b0;
    logic          init_done;
    logic          timeout_err;

    servant_spi_bus_arbiter #(
        .ADDRESS_WIDTH (AW),
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES    (GAP),
        .INIT_ENABLE   (1'b1)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .i_adr      (i_adr),
        .i_cyc      (i_cyc),
        .i_rdt      (i_rdt),
        .i_ack      (i_ack),
        .d_adr      (d_adr),
        .d_dat      (d_dat),
        .d_sel      (d_sel),
        .d_we       (d_we),
        .d_cyc      (d_cyc),
        .d_rdt      (d_rdt),
        .d_ack      (d_ack),
        .m_adr      (m_adr),
        .m_dat      (m_dat),
        .m_sel      (m_sel),
        .m_we       (m_we),
        .m_cyc      (m_cyc),
        .m_rdt      (m_rdt),
        .m_ack      (m_ack),
        .init_done  (init_done),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-3:0] adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        logic          we;
        int            gap;
        int            len;
    } burst_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdt;
    } ack_t;

    typedef struct {
        bit            has_req;
        bit            is_d;
        logic [AW-3:0] adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        logic          we;
        int            lat;
        logic [31:0]   rdt;
    } exp_t;

    int n_checks = 0;
    int n_pass   = 0;

    burst_t      mon_bursts[$];
    ack_t        mon_acks[$];
    exp_t        exp_q[$];
    int          slave_lat[$];
    logic [31:0] slave_rdt[$];

    bit          prev_cyc = 1'b0;
    bit          prev_init_done = 1'b0;
    bit          saw_i_ack = 1'b0;
    bit          saw_d_ack = 1'b0;
    int          cur_len = 0;
    int          low_cnt = 0;
    burst_t      cur;
    int          sample_no = 0;
    int          init_ack_at = -10;
    int          init_rise_at = -20;
    int          s_cnt = 0;
    int          s_lat = -1;
    logic [31:0] s_rdt = '0;

    bit          last_d = 1'b0;
    bit          err = 1'b0;
    bit          known_i = 1'b0;
    bit          known_d = 1'b0;
    logic [31:0] last_i_rdt = '0;
    logic [31:0] last_d_rdt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // One clock: slave and requester react after the edge, monitor samples at negedge.
    task automatic cycle();
        @(posedge clock);
        #1;
        if (saw_i_ack) i_cyc = 1'b0;
        if (saw_d_ack) d_cyc = 1'b0;
        if (m_cyc) begin
            if (s_cnt == 0) begin
                if (slave_lat.size() > 0) begin
                    s_lat = slave_lat.pop_front();
                    s_rdt = slave_rdt.pop_front();
                end else begin
                    s_lat = -1;
                    s_rdt = '0;
                end
            end
            m_ack = (s_cnt == s_lat);
            m_rdt = m_ack ? s_rdt : $urandom();
            s_cnt++;
        end else begin
            m_ack = 1'b0;
            m_rdt = $urandom();
            s_cnt = 0;
        end
        @(negedge clock);
        sample_no++;
        saw_i_ack = i_ack;
        saw_d_ack = d_ack;
        if (i_ack) mon_acks.push_back('{is_d: 1'b0, rdt: i_rdt});
        if (d_ack) mon_acks.push_back('{is_d: 1'b1, rdt: d_rdt});
        if (m_cyc && !prev_cyc) begin
            cur = '{adr: m_adr, dat: m_dat, sel: m_sel, we: m_we, gap: low_cnt, len: 0};
            cur_len = 1;
        end else if (m_cyc) begin
            cur_len++;
        end
        if (!m_cyc && prev_cyc) begin
            cur.len = cur_len;
            mon_bursts.push_back(cur);
            low_cnt = 1;
        end else if (!m_cyc) begin
            low_cnt++;
        end
        if (m_ack && m_cyc && m_we && m_sel == 4'h0 && m_adr == '0) init_ack_at = sample_no;
        if (init_done && !prev_init_done) init_rise_at = sample_no;
        prev_init_done = init_done;
        prev_cyc       = m_cyc;
    endtask

    task automatic finish_bursts();
        int          guard = 0;
        int          n_acks_exp = 0;
        bit          prev_to = 1'b0;
        bit          to;
        burst_t      b;
        ack_t        a;
        exp_t        e;
        logic [31:0] want;
        while (!(mon_bursts.size() >= exp_q.size() && !m_cyc && low_cnt >= 4) && guard < 400) begin
            cycle();
            guard++;
        end
        check("wait_bound", 32'(guard < 400), 32'd1);
        foreach (exp_q[k]) if (exp_q[k].has_req) n_acks_exp++;
        check("n_bursts", mon_bursts.size(), exp_q.size());
        check("n_acks", mon_acks.size(), n_acks_exp);
        foreach (exp_q[k]) begin
            e  = exp_q[k];
            to = (e.lat < 0) || (e.lat >= TO);
            if (mon_bursts.size() > 0) begin
                b = mon_bursts.pop_front();
                check("m_adr", b.adr, e.adr);
                check("m_dat", b.dat, e.dat);
                check("m_sel", b.sel, e.sel);
                check("m_we", b.we, e.we);
                check("cyc_len", b.len, to ? TO : e.lat + 1);
                if (k > 0) check("gap_len", b.gap, GAP + 1 + int'(prev_to));
            end
            if (e.has_req && mon_acks.size() > 0) begin
                a    = mon_acks.pop_front();
                want = to ? 32'hFFFF_FFFF : e.rdt;
                check("ack_bus", a.is_d, e.is_d);
                check("ack_rdt", a.rdt, want);
                if (e.is_d) begin
                    known_d    = 1'b1;
                    last_d_rdt = want;
                end else begin
                    known_i    = 1'b1;
                    last_i_rdt = want;
                end
            end
            err     = err | to;
            prev_to = to;
        end
        exp_q.delete();
        mon_bursts.delete();
        mon_acks.delete();
        check("timeout_err", timeout_err, err);
        check("init_done", init_done, 1'b1);
        if (known_i) check("i_rdt_hold", i_rdt, last_i_rdt);
        if (known_d) check("d_rdt_hold", d_rdt, last_d_rdt);
    endtask

    function automatic exp_t mk_req(input bit is_d, input logic [AW-3:0] ia, input logic [AW-3:0] da,
                                    input logic [31:0] dd, input logic [3:0] ds, input logic dw,
                                    input int lat, input logic [31:0] rdt);
        exp_t e;
        e.has_req = 1'b1;
        e.is_d    = is_d;
        e.adr     = is_d ? da : ia;
        e.dat     = is_d ? dd : 32'h0;
        e.sel     = is_d ? ds : 4'hF;
        e.we      = is_d ? dw : 1'b0;
        e.lat     = lat;
        e.rdt     = rdt;
        return e;
    endfunction

    // pat: 0 = instruction only, 1 = data only, 2 = both in the same cycle.
    task automatic run_txn(input int pat, input logic [AW-3:0] ia, input logic [AW-3:0] da,
                           input logic [31:0] dd, input logic [3:0] ds, input logic dw,
                           input int lat_a, input logic [31:0] rdt_a,
                           input int lat_b, input logic [31:0] rdt_b);
        bit first_d;
        first_d = (pat == 1) || (pat == 2 && !last_d);
        exp_q.push_back(mk_req(first_d, ia, da, dd, ds, dw, lat_a, rdt_a));
        slave_lat.push_back(lat_a);
        slave_rdt.push_back(rdt_a);
        if (pat == 2) begin
            exp_q.push_back(mk_req(!first_d, ia, da, dd, ds, dw, lat_b, rdt_b));
            slave_lat.push_back(lat_b);
            slave_rdt.push_back(rdt_b);
        end
        last_d = (pat == 2) ? !first_d : first_d;
        i_adr  = ia;
        d_adr  = da;
        d_dat  = dd;
        d_sel  = ds;
        d_we   = dw;
        i_cyc  = (pat != 1);
        d_cyc  = (pat != 0);
        cycle();
        check("grant_latency", m_cyc, 1'b1);
        finish_bursts();
    endtask

    // Reset for n_low cycles, then the config write followed by a pending instruction fetch.
    task automatic do_init(input int n_low, input int init_lat, input logic [AW-3:0] ia,
                           input int ilat, input logic [31:0] irdt);
        exp_t e;
        reset = 1'b0;
        #1;
        check("rst_mcyc_now", m_cyc, 1'b0);
        repeat (n_low) cycle();
        check("rst_mcyc", m_cyc, 1'b0);
        check("rst_iack", i_ack, 1'b0);
        check("rst_dack", d_ack, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        i_cyc = 1'b0;
        d_cyc = 1'b0;
        mon_bursts.delete();
        mon_acks.delete();
        slave_lat.delete();
        slave_rdt.delete();
        saw_i_ack    = 1'b0;
        saw_d_ack    = 1'b0;
        init_ack_at  = -10;
        init_rise_at = -20;
        last_d  = 1'b0;
        err     = 1'b0;
        known_i = 1'b0;
        known_d = 1'b0;
        reset   = 1'b1;
        e = '{has_req: 1'b0, is_d: 1'b0, adr: '0, dat: '0, sel: 4'h0, we: 1'b1, lat: init_lat, rdt: '0};
        exp_q.push_back(e);
        slave_lat.push_back(init_lat);
        slave_rdt.push_back(32'h0);
        exp_q.push_back(mk_req(1'b0, ia, '0, '0, '0, 1'b0, ilat, irdt));
        slave_lat.push_back(ilat);
        slave_rdt.push_back(irdt);
        repeat (3) cycle();
        i_adr = ia;
        i_cyc = 1'b1;
        finish_bursts();
        check("init_done_latency", init_rise_at, init_ack_at + 1);
    endtask

    function automatic int rand_lat();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return -1;
        if (r == 1) return TO - 1;
        if (r == 2) return TO;
        return $urandom_range(0, 12);
    endfunction

    task automatic rand_txn();
        run_txn($urandom_range(0, 2), AW'($urandom()), AW'($urandom()), $urandom(),
                4'($urandom_range(1, 15)), 1'($urandom()),
                rand_lat(), $urandom(), rand_lat(), $urandom());
    endtask

    initial begin
        do_init(3, 12, 22'h00_0abc, 2, 32'h1357_9bdf);
        run_txn(0, 22'h00_1234, 22'h0, 32'h0, 4'h1, 1'b0, 3, 32'hDEAD_BEEF, 0, 32'h0);
        for (int r = 0; r < 4; r++) begin
            run_txn(2, AW'($urandom()), AW'($urandom()), 32'hA5A5_A5A5, 4'b0110, 1'b1,
                    $urandom_range(0, 8), $urandom(), $urandom_range(0, 8), $urandom());
        end
        run_txn(1, 22'h0, 22'h00_0044, 32'h0bad_f00d, 4'hC, 1'b0, TO - 1, 32'h600D_CAFE, 0, 32'h0);
        run_txn(1, 22'h0, 22'h00_0055, 32'h1234_5678, 4'h3, 1'b1, -1, 32'h0, 0, 32'h0);
        for (int r = 0; r < 30; r++) rand_txn();
        d_adr = 22'h00_0077;
        d_sel = 4'hF;
        d_we  = 1'b0;
        d_cyc = 1'b1;
        slave_lat.push_back(-1);
        slave_rdt.push_back(32'h0);
        repeat (5) cycle();
        check("pre_reset_grant_d", m_cyc, 1'b1);
        do_init(1, 9, 22'h00_0321, 5, 32'h0F0F_0F0F);
        for (int r = 0; r < 6; r++) rand_txn();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
